// File: rtl/y86_regfile_if.sv
// Writeback/decode-side bus of the Y86-64 register file: commit results in,
// read ports and status out.
interface y86_regfile_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              instr_valid;
  logic              halt;
  logic [3:0]        dstE;
  logic [DATA_W-1:0] valE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_val;
  logic [CNT_W-1:0]  retired;
  logic              halted;

  modport master (
    output instr_valid, halt, dstE, valE, dstM, valM, srcA, srcB, dbg_sel,
    input  valA, valB, dbg_val, retired, halted
  );

  modport slave (
    input  instr_valid, halt, dstE, valE, dstM, valM, srcA, srcB, dbg_sel,
    output valA, valB, dbg_val, retired, halted
  );
endinterface

// File: rtl/y86_regfile.sv
// Y86-64 architectural register file: 15 registers, two decode read ports,
// a debug port, a retired-instruction counter and a sticky halt state.
module y86_regfile #(
  parameter int              DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter int              CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  y86_regfile_if.slave rf
);

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic              halted_q;
  logic [CNT_W-1:0]  retired_q;
  logic [DATA_W-1:0] regs [15];
  logic              commit;

  // The halting instruction itself never commits, so halt gates commit directly.
  assign commit = rf.instr_valid & (state == RUN) & ~rf.halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (rf.instr_valid && rf.halt) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // valM is checked first so it wins a dstE/dstM collision (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (i == 4) ? RSP_INIT : '0;
      end
      retired_q <= '0;
    end else if (commit) begin
      for (int i = 0; i < 15; i++) begin
        if (rf.dstM == 4'(i)) begin
          regs[i] <= rf.valM;
        end else if (rf.dstE == 4'(i)) begin
          regs[i] <= rf.valE;
        end
      end
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign rf.valA    = (rf.srcA    == RNONE) ? '0 : regs[rf.srcA];
  assign rf.valB    = (rf.srcB    == RNONE) ? '0 : regs[rf.srcB];
  assign rf.dbg_val = (rf.dbg_sel == RNONE) ? '0 : regs[rf.dbg_sel];
  assign rf.retired = retired_q;
  assign rf.halted  = halted_q;

endmodule

// File: doc/y86_regfile.md
Name: y86_regfile

Overview:
- Architectural register file for the Y86-64 sequential core. Sits directly downstream of the writeback stage and commits its dstE/valE and dstM/valM results on the clock edge.
- Serves the decode stage through two combinational read ports and one debug read port.
- Tracks retired instructions and holds a sticky halted state that blocks all architectural updates once the core halts.

Parameters:
- DATA_W, 64, register and data width in bits.
- RSP_INIT, 64'h0, reset value of %rsp (register 4).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  current instruction's writeback results are valid and commit this cycle.
- halt  input  1  current instruction is a halt or raised an exception.
- dstE  input  4  destination register ID for valE; 4'hF = none.
- valE  input  DATA_W  ALU result to write.
- dstM  input  4  destination register ID for valM; 4'hF = none.
- valM  input  DATA_W  memory result to write.
- srcA  input  4  read port A register ID.
- srcB  input  4  read port B register ID.
- valA  output  DATA_W  read port A data.
- valB  output  DATA_W  read port B data.
- dbg_sel  input  4  debug read register ID.
- dbg_val  output  DATA_W  debug read data.
- retired  output  CNT_W  count of committed instructions.
- halted  output  1  core is halted; sticky until reset.

Behaviour:
- Storage: 15 registers, IDs 0..14 (%rax..%r14). ID 4'hF (RNONE) is not storage.
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - all registers = 0, except reg 4 = RSP_INIT;
  - retired = 0; halted = 0.
- Reset deasserted mid-operation: the first possible commit is the first rising edge with rst_n=1.
- Reads are purely combinational:
  - valA = reg[srcA], valB = reg[srcB], dbg_val = reg[dbg_sel];
  - an ID of 4'hF reads as 0;
  - no internal bypass: a read in the same cycle as a write to the same register returns the pre-edge value; the new value is visible after the edge.
- Commit condition: commit = instr_valid & ~halted & ~halt.
- On a rising edge with commit=1:
  - if dstE != 4'hF, reg[dstE] <= valE;
  - if dstM != 4'hF, reg[dstM] <= valM;
  - if dstE == dstM != 4'hF, valM wins (popq %rsp semantics);
  - retired <= retired + 1, wrapping modulo 2^CNT_W with no saturation.
- With commit=0, no register or counter changes.
- Halt state machine, two states:
  - RUN (halted=0): on a rising edge with instr_valid=1 and halt=1, go to HALTED. The halting instruction performs no register write and is not counted.
  - HALTED (halted=1): stays there regardless of inputs; only rst_n=0 returns to RUN.
  - halt with instr_valid=0 is ignored.
- Writes with only one destination valid (e.g. irmovq: dstM=F) touch only that register.
- Both destinations set to F gives no register change, but the counter still increments when commit=1 (e.g. nop, jXX).
- Outputs retired and halted are registered. valA/valB/dbg_val are combinational from state and inputs.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with RSP_INIT=64'h100 -> immediately reg4=0x100, all other regs 0, retired=0, halted=0. valA reads 0 for srcA=4'hF.
- Dual write: instr_valid=1, dstE=2 valE=0x11, dstM=3 valM=0x22, one edge -> reg2=0x11, reg3=0x22, retired=1. Same cycle srcA=2 still reads 0 (no bypass); next cycle reads 0x11.
- Conflict: dstE=4 valE=0x1F8, dstM=4 valM=0xABCD, instr_valid=1 -> reg4=0xABCD, retired increments by 1.
- Gating: instr_valid=0, dstE=1 valE=0x55 -> reg1 unchanged, retired unchanged. Then dstE=dstM=F with instr_valid=1 -> no reg change, retired+1.
- Halt: instr_valid=1, halt=1, dstE=5 valE=0x99 -> reg5 unchanged, retired unchanged, halted=1. Subsequent valid writes to reg5 are ignored for 10 cycles. rst_n pulse -> halted=0.
- Wrap: with CNT_W=4, 16 commits from reset -> retired returns to 0. Verify dbg_sel sweep 0..15 returns written values, and 0 for ID 15.
